nb_solver_param: RTL and testbench

//  Parametrised number-baseball solver; successor to the fixed 4-digit solver.

---
 rtl/nb_solver_param_pkg.sv | 29 ++
 rtl/nb_solver_param_score.sv | 31 +++
 rtl/nb_solver_param.sv | 272 +++++++++++++++++++++++++++
 tb/tb_nb_solver_param.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nb_solver_param_pkg.sv
// Shared types and helpers for the parametrised number-baseball solver.
// Codes are digit-packed with digit 0 in the most significant DIGIT_W bits.
package nb_solver_param_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SEARCH     = 3'd1,
      ST_CHECK      = 3'd2,
      ST_ASK        = 3'd3,
      ST_WAIT_REPLY = 3'd4,
      ST_DONE       = 3'd5
   } state_e;

   // Width of a strike or ball count for an n-digit code.
   function automatic int unsigned score_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Width of a guess counter that must reach g.
   function automatic int unsigned gc_w(input int unsigned g);
      return $clog2(g + 1);
   endfunction

   // Bit offset of digit i within an n-digit, dw-bit-per-digit packed code.
   function automatic int digit_lsb(input int i, input int unsigned n, input int unsigned dw);
      return (int'(n) - 1 - i) * int'(dw);
   endfunction

endpackage

// File: rtl/nb_solver_param_score.sv
// Combinational strike/ball score of two digit-packed codes.
// Both codes are assumed to hold distinct digits, so ball never overcounts.
module nb_solver_param_score
   import nb_solver_param_pkg::*;
#(
   parameter  int unsigned NUM_DIGITS = 4,
   parameter  int unsigned DIGIT_W    = 4,
   localparam int unsigned CW         = NUM_DIGITS * DIGIT_W,
   localparam int unsigned SW         = score_w(NUM_DIGITS)
) (
   input  logic [CW-1:0] code_a,
   input  logic [CW-1:0] code_b,
   output logic [SW-1:0] strike_c,
   output logic [SW-1:0] ball_c
);

   always_comb begin
      strike_c = '0;
      ball_c   = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (code_a[digit_lsb(i, NUM_DIGITS, DIGIT_W) +: DIGIT_W] ==
                code_b[digit_lsb(k, NUM_DIGITS, DIGIT_W) +: DIGIT_W]) begin
               if (i == k) strike_c = strike_c + SW'(1);
               else        ball_c   = ball_c + SW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/nb_solver_param.sv
// Parametrised number-baseball solver: asks the lexically next candidate that is
// consistent with every stored (question, strike, ball) entry until solved or out of options.
module nb_solver_param
   import nb_solver_param_pkg::*;
#(
   parameter  int unsigned NUM_DIGITS  = 4,
   parameter  int unsigned RADIX       = 10,
   parameter  int unsigned DIGIT_W     = 4,
   parameter  int unsigned MAX_GUESSES = 16,
   localparam int unsigned CW          = NUM_DIGITS * DIGIT_W,
   localparam int unsigned SW          = score_w(NUM_DIGITS),
   localparam int unsigned GC_W        = gc_w(MAX_GUESSES)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [CW-1:0]   question,
   output logic            ask_valid,
   input  logic            ask_ready,
   input  logic            reply_valid,
   output logic            reply_ready,
   input  logic            correct,
   input  logic [SW-1:0]   strike,
   input  logic [SW-1:0]   ball,
   output logic            busy,
   output logic            done,
   output logic            solved,
   output logic [GC_W-1:0] guess_count
);

   localparam int unsigned HW = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;

   state_e          state_q, state_d;
   logic [CW-1:0]   cand_q, cand_d;
   logic [HW-1:0]   hist_cnt_q, hist_cnt_d;
   logic [HW-1:0]   j_q, j_d;
   logic [CW-1:0]   question_q, question_d;
   logic            ask_valid_q, ask_valid_d;
   logic            reply_ready_q, reply_ready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            solved_q, solved_d;
   logic [GC_W-1:0] guess_count_q, guess_count_d;

   logic [CW-1:0]   hist_qn_q [MAX_GUESSES];
   logic [SW-1:0]   hist_s_q  [MAX_GUESSES];
   logic [SW-1:0]   hist_b_q  [MAX_GUESSES];
   logic            hist_push;

   logic            cand_ok;
   logic [CW-1:0]   cand_inc;
   logic            cand_wrap;
   logic [CW-1:0]   first_code;
   logic [DIGIT_W-1:0] inc_dig;
   logic            inc_carry;
   logic [SW-1:0]   sc_strike, sc_ball;
   logic            hist_match;
   logic            hist_last;
   logic            reply_hit;
   logic            hist_full;
   logic            ask_fire;

   assign question    = question_q;
   assign ask_valid   = ask_valid_q;
   assign reply_ready = reply_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign solved      = solved_q;
   assign guess_count = guess_count_q;

   // Candidate legality: every digit below RADIX and no digit repeated.
   always_comb begin
      cand_ok = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (32'(cand_q[digit_lsb(i, NUM_DIGITS, DIGIT_W) +: DIGIT_W]) >= RADIX) cand_ok = 1'b0;
         for (int k = i + 1; k < int'(NUM_DIGITS); k++) begin
            if (cand_q[digit_lsb(i, NUM_DIGITS, DIGIT_W) +: DIGIT_W] ==
                cand_q[digit_lsb(k, NUM_DIGITS, DIGIT_W) +: DIGIT_W]) cand_ok = 1'b0;
         end
      end
   end

   // Mixed radix-R increment, carry rippling from the least significant digit.
   always_comb begin
      cand_inc  = cand_q;
      inc_carry = 1'b1;
      inc_dig   = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         inc_dig = cand_q[digit_lsb(i, NUM_DIGITS, DIGIT_W) +: DIGIT_W];
         if (inc_carry) begin
            if (32'(inc_dig) >= RADIX - 1) begin
               inc_dig = '0;
            end else begin
               inc_dig   = inc_dig + DIGIT_W'(1);
               inc_carry = 1'b0;
            end
         end
         cand_inc[digit_lsb(i, NUM_DIGITS, DIGIT_W) +: DIGIT_W] = inc_dig;
      end
      cand_wrap = inc_carry;
   end

   always_comb begin
      first_code = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         first_code[digit_lsb(i, NUM_DIGITS, DIGIT_W) +: DIGIT_W] = DIGIT_W'(i);
      end
   end

   nb_solver_param_score #(
      .NUM_DIGITS (NUM_DIGITS),
      .DIGIT_W    (DIGIT_W)
   ) u_score (
      .code_a   (cand_q),
      .code_b   (hist_qn_q[j_q]),
      .strike_c (sc_strike),
      .ball_c   (sc_ball)
   );

   assign hist_match = (sc_strike == hist_s_q[j_q]) && (sc_ball == hist_b_q[j_q]);
   assign hist_last  = (j_q == hist_cnt_q - HW'(1));
   assign reply_hit  = correct || (strike == SW'(NUM_DIGITS));
   assign hist_full  = (hist_cnt_q == HW'(MAX_GUESSES - 1));
   assign ask_fire   = ask_valid_q && ask_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cand_q        <= '0;
         hist_cnt_q    <= '0;
         j_q           <= '0;
         question_q    <= '0;
         ask_valid_q   <= 1'b0;
         reply_ready_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         solved_q      <= 1'b0;
         guess_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cand_q        <= cand_d;
         hist_cnt_q    <= hist_cnt_d;
         j_q           <= j_d;
         question_q    <= question_d;
         ask_valid_q   <= ask_valid_d;
         reply_ready_q <= reply_ready_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         solved_q      <= solved_d;
         guess_count_q <= guess_count_d;
      end
   end

   // History storage is only read below hist_cnt, so it needs no reset.
   always_ff @(posedge clk) begin
      if (hist_push) begin
         hist_qn_q[hist_cnt_q] <= question_q;
         hist_s_q[hist_cnt_q]  <= strike;
         hist_b_q[hist_cnt_q]  <= ball;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) state_d = ST_SEARCH;
         end
         ST_SEARCH: begin
            if (!cand_ok) begin
               if (cand_wrap) state_d = ST_DONE;
            end else if (hist_cnt_q == '0) begin
               state_d = ST_ASK;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!hist_match)    state_d = ST_SEARCH;
            else if (hist_last) state_d = ST_ASK;
         end
         ST_ASK: begin
            if (ask_fire) state_d = ST_WAIT_REPLY;
         end
         ST_WAIT_REPLY: begin
            if (reply_valid) begin
               if (reply_hit || hist_full) state_d = ST_DONE;
               else                        state_d = ST_SEARCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cand_d        = cand_q;
      hist_cnt_d    = hist_cnt_q;
      j_d           = j_q;
      question_d    = question_q;
      ask_valid_d   = ask_valid_q;
      reply_ready_d = reply_ready_q;
      busy_d        = busy_q;
      done_d        = done_q;
      solved_d      = solved_q;
      guess_count_d = guess_count_q;
      hist_push     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               cand_d        = first_code;
               hist_cnt_d    = '0;
               guess_count_d = '0;
               done_d        = 1'b0;
               solved_d      = 1'b0;
               busy_d        = 1'b1;
            end
         end
         ST_SEARCH: begin
            if (!cand_ok) begin
               cand_d = cand_inc;
               if (cand_wrap) begin
                  done_d   = 1'b1;
                  solved_d = 1'b0;
                  busy_d   = 1'b0;
               end
            end else if (hist_cnt_q == '0) begin
               question_d  = cand_q;
               ask_valid_d = 1'b1;
            end else begin
               j_d = '0;
            end
         end
         ST_CHECK: begin
            if (!hist_match) begin
               cand_d = cand_inc;
            end else if (hist_last) begin
               question_d  = cand_q;
               ask_valid_d = 1'b1;
            end else begin
               j_d = j_q + HW'(1);
            end
         end
         ST_ASK: begin
            if (ask_fire) begin
               guess_count_d = guess_count_q + GC_W'(1);
               ask_valid_d   = 1'b0;
               reply_ready_d = 1'b1;
            end
         end
         ST_WAIT_REPLY: begin
            if (reply_valid) begin
               reply_ready_d = 1'b0;
               if (reply_hit) begin
                  done_d   = 1'b1;
                  solved_d = 1'b1;
                  busy_d   = 1'b0;
               end else if (hist_full) begin
                  done_d   = 1'b1;
                  solved_d = 1'b0;
                  busy_d   = 1'b0;
               end else begin
                  hist_push  = 1'b1;
                  hist_cnt_d = hist_cnt_q + HW'(1);
                  cand_d     = cand_inc;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_nb_solver_param.sv
// Self-checking bench: a reference solver model predicts every question and the
// final outcome; a behavioural grader answers the DUT over the handshakes.
module tb_nb_solver_param;

   logic        clk;
   logic        reset, start, ask_ready, reply_valid, correct;
   logic [2:0]  strike, ball;
   int          sel;
   int          n_vec, n_err;
   logic [31:0] exp_qs  [$];
   logic [31:0] exp_res [$];

   logic        start_a, start_b, start_c;
   logic [15:0] a_q, b_q;
   logic [11:0] c_q;
   logic        a_av, b_av, c_av, a_rr, b_rr, c_rr;
   logic        a_busy, b_busy, c_busy, a_done, b_done, c_done;
   logic        a_sol, b_sol, c_sol;
   logic [4:0]  a_gc, c_gc;
   logic [1:0]  b_gc;

   logic [31:0] cur_q;
   logic        cur_av, cur_rr, cur_busy, cur_done, cur_sol;
   logic [7:0]  cur_gc;

   assign start_a = start && (sel == 0);
   assign start_b = start && (sel == 1);
   assign start_c = start && (sel == 2);

   nb_solver_param u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .question(a_q), .ask_valid(a_av),
      .ask_ready(ask_ready), .reply_valid(reply_valid), .reply_ready(a_rr), .correct(correct),
      .strike(strike), .ball(ball), .busy(a_busy), .done(a_done), .solved(a_sol),
      .guess_count(a_gc));

   nb_solver_param #(.MAX_GUESSES(2)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .question(b_q), .ask_valid(b_av),
      .ask_ready(ask_ready), .reply_valid(reply_valid), .reply_ready(b_rr), .correct(correct),
      .strike(strike), .ball(ball), .busy(b_busy), .done(b_done), .solved(b_sol),
      .guess_count(b_gc));

   nb_solver_param #(.NUM_DIGITS(3), .RADIX(6)) u_dut_c (
      .clk(clk), .reset(reset), .start(start_c), .question(c_q), .ask_valid(c_av),
      .ask_ready(ask_ready), .reply_valid(reply_valid), .reply_ready(c_rr), .correct(correct),
      .strike(strike[1:0]), .ball(ball[1:0]), .busy(c_busy), .done(c_done), .solved(c_sol),
      .guess_count(c_gc));

   always_comb begin
      case (sel)
         1: begin
            cur_q = 32'(b_q); cur_av = b_av; cur_rr = b_rr; cur_busy = b_busy;
            cur_done = b_done; cur_sol = b_sol; cur_gc = 8'(b_gc);
         end
         2: begin
            cur_q = 32'(c_q); cur_av = c_av; cur_rr = c_rr; cur_busy = c_busy;
            cur_done = c_done; cur_sol = c_sol; cur_gc = 8'(c_gc);
         end
         default: begin
            cur_q = 32'(a_q); cur_av = a_av; cur_rr = a_rr; cur_busy = a_busy;
            cur_done = a_done; cur_sol = a_sol; cur_gc = 8'(a_gc);
         end
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int n_of(input int s);
      return (s == 2) ? 3 : 4;
   endfunction
   function automatic int r_of(input int s);
      return (s == 2) ? 6 : 10;
   endfunction
   function automatic int g_of(input int s);
      return (s == 1) ? 2 : 16;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void grade(input logic [31:0] q, input logic [31:0] s, input int n,
                                 output int st, output int bl);
      st = 0;
      bl = 0;
      for (int i = 0; i < n; i++)
         for (int k = 0; k < n; k++)
            if (q[(n-1-i)*4 +: 4] == s[(n-1-k)*4 +: 4]) begin
               if (i == k) st++;
               else        bl++;
            end
   endfunction

   function automatic bit code_ok(input logic [31:0] c, input int n, input int r);
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (int'(c[(n-1-i)*4 +: 4]) >= r) ok = 1'b0;
         for (int k = i + 1; k < n; k++)
            if (c[(n-1-i)*4 +: 4] == c[(n-1-k)*4 +: 4]) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [31:0] to_code(input int v, input int n, input int r);
      logic [31:0] c;
      int          t;
      c = '0;
      t = v;
      for (int i = n - 1; i >= 0; i--) begin
         c[(n-1-i)*4 +: 4] = 4'(t % r);
         t = t / r;
      end
      return c;
   endfunction

   // Reference solver: enumerates codes numerically and queues each expected question.
   function automatic void model_game(input int n, input int r, input int g, input logic [31:0] secret,
                                      input bit lie, output bit m_sol, output int m_gc);
      logic [31:0] hq [$];
      int          hs [$];
      int          hb [$];
      int          total, v, st, bl;
      logic [31:0] code;
      bit          ok, fin;
      total = 1;
      for (int i = 0; i < n; i++) total = total * r;
      v = 0;
      for (int i = 0; i < n; i++) v = v * r + i;
      m_sol = 1'b0;
      m_gc  = 0;
      fin   = 1'b0;
      code  = '0;
      while (!fin) begin
         ok = 1'b0;
         while (!ok && v < total) begin
            code = to_code(v, n, r);
            ok   = code_ok(code, n, r);
            for (int j = 0; j < hq.size() && ok; j++) begin
               grade(code, hq[j], n, st, bl);
               if (st != hs[j] || bl != hb[j]) ok = 1'b0;
            end
            if (!ok) v++;
         end
         if (!ok) begin
            fin = 1'b1;
         end else begin
            exp_qs.push_back(code);
            m_gc++;
            grade(code, secret, n, st, bl);
            if (lie) begin st = 0; bl = 0; end
            if (!lie && st == n) begin
               m_sol = 1'b1;
               fin   = 1'b1;
            end else if (m_gc == g) begin
               fin = 1'b1;
            end else begin
               hq.push_back(code);
               hs.push_back(st);
               hb.push_back(bl);
               v++;
            end
         end
      end
   endfunction

   task automatic play(input int s, input logic [31:0] secret, input bit lie, input int stall,
                       input logic [31:0] first_q, input string tag);
      bit          m_sol;
      int          m_gc, qn, wc, st, bl, n, r;
      logic [31:0] eq, held, res;
      n = n_of(s);
      r = r_of(s);
      exp_qs.delete();
      model_game(n, r, g_of(s), secret, lie, m_sol, m_gc);
      res     = 32'(m_gc);
      res[16] = m_sol;
      exp_res.push_back(res);
      @(negedge clk);
      sel   = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, ":busy"}, 32'(cur_busy), 32'd1);
      chk({tag, ":av_early"}, 32'(cur_av), 32'd0);
      qn = 0;
      while (qn < 40) begin
         wc = 0;
         while (!cur_av && !cur_done && wc < 20000) begin
            @(negedge clk);
            wc++;
         end
         if (!cur_av) break;
         if (qn == 0) begin
            chk({tag, ":latency"}, 32'(wc), 32'd1);
            chk({tag, ":first_q"}, cur_q, first_q);
         end
         eq = (exp_qs.size() > 0) ? exp_qs.pop_front() : 32'hFFFF_FFFF;
         chk({tag, ":q"}, cur_q, eq);
         chk({tag, ":qdigits"}, 32'(code_ok(cur_q, n, r)), 32'd1);
         chk({tag, ":gc_pre"}, 32'(cur_gc), 32'(qn));
         if (qn == 0 && stall > 0) begin
            held      = cur_q;
            ask_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
               @(negedge clk);
               chk({tag, ":stall_av"}, 32'(cur_av), 32'd1);
               chk({tag, ":stall_q"}, cur_q, held);
               chk({tag, ":stall_gc"}, 32'(cur_gc), 32'd0);
            end
         end
         ask_ready = 1'b1;
         @(negedge clk);
         ask_ready = 1'b0;
         qn++;
         chk({tag, ":hs_av_rr"}, 32'({cur_av, cur_rr}), 32'd1);
         chk({tag, ":gc_post"}, 32'(cur_gc), 32'(qn));
         grade(cur_q, secret, n, st, bl);
         if (lie) begin st = 0; bl = 0; end
         strike      = 3'(st);
         ball        = 3'(bl);
         correct     = !lie && (st == n);
         reply_valid = 1'b1;
         @(negedge clk);
         reply_valid = 1'b0;
         correct     = 1'b0;
         strike      = '0;
         ball        = '0;
         chk({tag, ":rr_drop"}, 32'(cur_rr), 32'd0);
      end
      res = exp_res.pop_front();
      chk({tag, ":done"}, 32'(cur_done), 32'd1);
      chk({tag, ":solved"}, 32'(cur_sol), 32'(res[16]));
      chk({tag, ":guess_count"}, 32'(cur_gc), 32'(res[15:0]));
      chk({tag, ":busy_end"}, 32'(cur_busy), 32'd0);
      chk({tag, ":q_left"}, 32'(exp_qs.size()), 32'd0);
   endtask

   task automatic reset_mid();
      int w;
      @(negedge clk);
      sel   = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (!cur_av && w < 100) begin
         @(negedge clk);
         w++;
      end
      ask_ready = 1'b1;
      @(negedge clk);
      ask_ready = 1'b0;
      chk("rst_mid:in_wait", 32'(cur_rr), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid:q", cur_q, 32'd0);
      chk("rst_mid:av", 32'(cur_av), 32'd0);
      chk("rst_mid:rr", 32'(cur_rr), 32'd0);
      chk("rst_mid:busy", 32'(cur_busy), 32'd0);
      chk("rst_mid:done", 32'(cur_done), 32'd0);
      chk("rst_mid:solved", 32'(cur_sol), 32'd0);
      chk("rst_mid:gc", 32'(cur_gc), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;  n_err = 0;  sel = 0;
      reset = 1'b1;  start = 1'b0;  ask_ready = 1'b0;
      reply_valid = 1'b0;  correct = 1'b0;  strike = '0;  ball = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk("reset:q", cur_q, 32'd0);
         chk("reset:av_rr_busy", 32'({cur_av, cur_rr, cur_busy}), 32'd0);
         chk("reset:done_solved_gc", 32'({cur_done, cur_sol, cur_gc}), 32'd0);
      end

      play(0, 32'h0123, 1'b0, 0, 32'h0123, "secret_0123");
      chk("secret_0123:one_guess", 32'(cur_gc), 32'd1);
      chk("secret_0123:solved_now", 32'(cur_sol), 32'd1);
      play(0, 32'h9876, 1'b0, 0, 32'h0123, "secret_9876");
      play(0, 32'h3210, 1'b0, 5, 32'h0123, "backpressure");
      play(0, 32'h0123, 1'b1, 0, 32'h0123, "liar");
      chk("liar:fail", 32'(cur_sol), 32'd0);
      play(1, 32'h5678, 1'b0, 0, 32'h0123, "limit2");
      chk("limit2:gc2", 32'(cur_gc), 32'd2);
      chk("limit2:fail", 32'(cur_sol), 32'd0);
      reset_mid();
      play(2, 32'h0540, 1'b0, 0, 32'h0012, "n3_r6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
